// File: rtl/lu_pkg.sv
// rtl/lu_pkg.sv - opcode and control-state definitions shared by the logic unit
package lu_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_NAND = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_NOT  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    typedef enum logic {
        LU_EMPTY = 1'b0,
        LU_FULL  = 1'b1
    } lu_state_e;

endpackage

// File: rtl/lu_bitop.sv
// rtl/lu_bitop.sv - combinational eight-way bitwise operator on WIDTH-bit operands
module lu_bitop #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] r
);

    logic [WIDTH-1:0] r_and;
    logic [WIDTH-1:0] r_or;
    logic [WIDTH-1:0] r_xor;
    logic [WIDTH-1:0] base;
    logic             inv;

    // op[0] selects the inverted form, except in the A pair where PASS (111) is the true form
    assign inv = op[0] ^ (op[2] & op[1]);

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            and g_and (r_and[i], a[i], b[i]);
            or  g_or  (r_or[i],  a[i], b[i]);
            xor g_xor (r_xor[i], a[i], b[i]);
            xor g_inv (r[i], base[i], inv);
        end
    endgenerate

    always_comb begin
        base = a;
        case (op[2:1])
            2'b00:   base = r_and;
            2'b01:   base = r_or;
            2'b10:   base = r_xor;
            default: base = a;
        endcase
    end

endmodule

// File: rtl/lu_pipe_acc.sv
// rtl/lu_pipe_acc.sv - registered logic unit with accumulator mode and valid/ready handshake
module lu_pipe_acc
    import lu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc_en,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             zero,
    output logic             ones,
    output logic [CNT_W-1:0] op_count
);

    lu_state_e        state_q;
    lu_state_e        state_d;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] s_q;
    logic             zero_q;
    logic             ones_q;
    logic [CNT_W-1:0] op_count_q;
    logic             accept;
    logic             drain;

    assign out_valid = (state_q == LU_FULL);
    assign in_ready  = !reset && !clear && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    assign op_a = acc_en ? acc_q : a;

    lu_bitop #(
        .WIDTH(WIDTH)
    ) u_bitop (
        .a  (op_a),
        .b  (b),
        .op (op),
        .r  (result)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            LU_EMPTY: if (accept)    state_d = LU_FULL;
            LU_FULL:  if (out_ready) state_d = accept ? LU_FULL : LU_EMPTY;
            default:                 state_d = LU_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= LU_EMPTY;
            s_q        <= '0;
            zero_q     <= 1'b1;
            ones_q     <= 1'b0;
            acc_q      <= '0;
            op_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                s_q    <= result;
                zero_q <= (result == '0);
                ones_q <= &result;
            end
            // clear blocks accept, so the two acc_q writes never collide
            if (clear) begin
                acc_q <= '0;
            end else if (accept && acc_en) begin
                acc_q <= result;
            end
            if (clear) begin
                op_count_q <= '0;
            end else if (drain && !(&op_count_q)) begin
                op_count_q <= op_count_q + CNT_W'(1);
            end
        end
    end

    assign s        = s_q;
    assign zero     = zero_q;
    assign ones     = ones_q;
    assign op_count = op_count_q;

endmodule

// File: tb/tb_lu_pipe_acc.sv
// tb/tb_lu_pipe_acc.sv - directed self-checking bench for lu_pipe_acc
module tb_lu_pipe_acc;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [3:0]  a, b;
    logic [2:0]  op;
    logic        acc_en, clear;
    logic        out_valid, out_ready;
    logic [3:0]  s;
    logic        zero, ones;
    logic [1:0]  op_count;

    logic        w1_in_ready, w1_out_valid, w1_zero, w1_ones;
    logic [0:0]  w1_s;
    logic [1:0]  w1_cnt;
    logic        w16_in_ready, w16_out_valid, w16_zero, w16_ones;
    logic [15:0] a16, b16, w16_s;
    logic [1:0]  w16_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lu_pipe_acc #(.WIDTH(4), .CNT_W(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .acc_en(acc_en), .clear(clear),
        .out_valid(out_valid), .out_ready(out_ready), .s(s), .zero(zero),
        .ones(ones), .op_count(op_count)
    );

    lu_pipe_acc #(.WIDTH(1), .CNT_W(2)) dut_w1 (
        .clk(clk), .reset(reset), .in_valid(1'b1), .in_ready(w1_in_ready),
        .a(a[0:0]), .b(b[0:0]), .op(op), .acc_en(1'b0), .clear(1'b0),
        .out_valid(w1_out_valid), .out_ready(1'b1), .s(w1_s), .zero(w1_zero),
        .ones(w1_ones), .op_count(w1_cnt)
    );

    lu_pipe_acc #(.WIDTH(16), .CNT_W(2)) dut_w16 (
        .clk(clk), .reset(reset), .in_valid(1'b1), .in_ready(w16_in_ready),
        .a(a16), .b(b16), .op(op), .acc_en(1'b0), .clear(1'b0),
        .out_valid(w16_out_valid), .out_ready(1'b1), .s(w16_s), .zero(w16_zero),
        .ones(w16_ones), .op_count(w16_cnt)
    );

    assign a16 = {a, b, ~a, a ^ b};
    assign b16 = {b, a, b, ~b};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] lu_model(input logic [2:0] o, input logic [15:0] x,
                                             input logic [15:0] y);
        case (o)
            3'd0:    return x & y;
            3'd1:    return ~(x & y);
            3'd2:    return x | y;
            3'd3:    return ~(x | y);
            3'd4:    return x ^ y;
            3'd5:    return ~(x ^ y);
            3'd6:    return ~x;
            default: return x;
        endcase
    endfunction

    initial begin
        logic [3:0]  acc_exp;
        logic [3:0]  bseq [5];
        logic [1:0]  cnt_exp [5];
        logic [15:0] e16;
        logic [3:0]  e4;
        logic        e1;

        reset = 1'b1; in_valid = 1'b1; a = 4'h0; b = 4'h0; op = 3'b111;
        acc_en = 1'b0; clear = 1'b0; out_ready = 1'b1;

        // 1: power-up reset, then reset mid-stream with a pending result
        tick(); tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_flags", 32'({s, zero, ones}), 32'({4'h0, 1'b1, 1'b0}));
        chk("rst_count", 32'(op_count), 32'd0);
        reset = 1'b0; a = 4'hF; out_ready = 1'b0;
        tick();
        chk("pend_out_valid", 32'(out_valid), 32'd1);
        chk("pend_s", 32'(s), 32'hF);
        reset = 1'b1; out_ready = 1'b1;
        #1 chk("midrst_in_ready", 32'(in_ready), 32'd0);
        tick(); tick();
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_flags", 32'({s, zero, ones}), 32'({4'h0, 1'b1, 1'b0}));
        chk("midrst_count", 32'(op_count), 32'd0);
        reset = 1'b0; in_valid = 1'b0;
        tick();
        chk("post_rst_no_pulse", 32'(out_valid), 32'd0);

        // 2: OR, NOR, AND
        in_valid = 1'b1; op = 3'b010; a = 4'b0101; b = 4'b0011;
        tick();
        chk("or_s", 32'({out_valid, s, zero}), 32'({1'b1, 4'b0111, 1'b0}));
        op = 3'b011;
        tick();
        chk("nor_s", 32'({s, zero}), 32'({4'b1000, 1'b0}));
        op = 3'b000; a = 4'b1010; b = 4'b0101;
        tick();
        chk("and_s", 32'({s, zero}), 32'({4'b0000, 1'b1}));

        // 3: accumulator XOR chain; a is garbage and must be ignored
        acc_en = 1'b1; a = 4'b1111; op = 3'b100; b = 4'b0011;
        tick();
        chk("acc_xor1", 32'(s), 32'b0011);
        b = 4'b0101;
        tick();
        chk("acc_xor2", 32'(s), 32'b0110);
        op = 3'b111; b = 4'b0000;
        tick();
        chk("acc_pass", 32'(s), 32'b0110);

        // 4: backpressure holding an all-ones result
        acc_en = 1'b0; op = 3'b111; a = 4'hF;
        tick();
        chk("bp_first", 32'({s, ones}), 32'({4'hF, 1'b1}));
        out_ready = 1'b0; a = 4'h0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
            chk("bp_hold", 32'({out_valid, s, ones}), 32'({1'b1, 4'hF, 1'b1}));
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        chk("bp_next", 32'({s, zero, ones}), 32'({4'h0, 1'b1, 1'b0}));
        in_valid = 1'b0;
        tick();
        chk("drain_only", 32'({out_valid, s}), 32'({1'b0, 4'h0}));

        // 5: counter saturation and clear
        clear = 1'b1;
        #1 chk("clr_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("clr_count", 32'(op_count), 32'd0);
        clear = 1'b0; in_valid = 1'b1; acc_en = 1'b1; op = 3'b010;
        bseq    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        cnt_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
        acc_exp = 4'h0;
        for (int i = 0; i < 5; i++) begin
            b = bseq[i];
            acc_exp = acc_exp | bseq[i];
            tick();
            chk("cnt_acc_s", 32'(s), 32'(acc_exp));
            chk("cnt_val", 32'(op_count), 32'(cnt_exp[i]));
        end
        in_valid = 1'b0;
        tick();
        chk("cnt_sat", 32'(op_count), 32'd3);
        clear = 1'b1;
        #1 chk("clr2_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("clr2_count", 32'(op_count), 32'd0);
        clear = 1'b0; in_valid = 1'b1; op = 3'b111; out_ready = 1'b0;
        tick();
        chk("acc_cleared", 32'({out_valid, s, zero}), 32'({1'b1, 4'h0, 1'b1}));
        clear = 1'b1; out_ready = 1'b1;
        tick();
        chk("clr_drain_uncounted", 32'({out_valid, op_count}), 32'({1'b0, 2'd0}));
        clear = 1'b0; acc_en = 1'b0;

        // 6: exhaustive sweep on WIDTH=4, mirrored onto WIDTH=1 and WIDTH=16
        for (int o = 0; o < 8; o++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    op = 3'(o); a = 4'(x); b = 4'(y);
                    #1;
                    e16 = lu_model(op, a16, b16);
                    e4  = 4'(lu_model(op, 16'(a), 16'(b)));
                    e1  = 1'(lu_model(op, 16'(a[0]), 16'(b[0])));
                    tick();
                    chk("sweep_w4", 32'({s, zero, ones}), 32'({e4, e4 == 4'h0, &e4}));
                    chk("sweep_w1", 32'({w1_s, w1_zero, w1_ones}), 32'({e1, !e1, e1}));
                    chk("sweep_w16", 32'({w16_s, w16_zero, w16_ones}),
                        32'({e16, e16 == 16'h0, &e16}));
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
